// File: rtl/speck_encrypt_iter.sv
// SPECK block encryption, one round per clock.
// A start in IDLE/FINISHED loads the plaintext. Each RUN cycle then applies one
// round. After the last round the ciphertext is registered and done stays high
// until the next accepted start.
module speck_encrypt_iter #(
  parameter int W      = 32,
  parameter int ROUNDS = 27,
  parameter int ALPHA  = 8,
  parameter int BETA   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [W-1:0]        pt_x,
  input  logic [W-1:0]        pt_y,
  input  logic [W*ROUNDS-1:0] rk_flat,
  output logic [W-1:0]        ct_x,
  output logic [W-1:0]        ct_y,
  output logic                done,
  output logic                busy
);

  // The counter has to be able to hold ROUNDS. The key table is padded to a
  // power of two so the counter can index it at full width. Padding entries
  // are never selected while running.
  localparam int RW = $clog2(ROUNDS + 1);
  localparam int KN = 1 << RW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    FINISHED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [RW-1:0]   round_q, round_d;
  logic [W-1:0]    ct_x_q, ct_x_d;
  logic [W-1:0]    ct_y_q, ct_y_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [W-1:0]    rk_arr [KN];
  logic [W-1:0]    round_key;
  logic [W-1:0]    x_ror;
  logic [W-1:0]    y_rol;
  logic [W-1:0]    x_new;
  logic [W-1:0]    y_new;
  logic            last_round;
  logic            accept;

  // Unpack the flat key bus into a table indexed by the round counter.
  generate
    for (genvar gi = 0; gi < KN; gi++) begin : g_rk
      if (gi < ROUNDS) begin : g_used
        assign rk_arr[gi] = rk_flat[W*gi +: W];
      end else begin : g_pad
        assign rk_arr[gi] = '0;
      end
    end
  endgenerate

  // One SPECK round on the current state. The key is read live from rk_flat.
  // The addition wraps and its carry-out is dropped.
  always_comb begin
    round_key  = rk_arr[round_q];
    x_ror      = (x_q >> ALPHA) | (x_q << (W - ALPHA));
    y_rol      = (y_q << BETA) | (y_q >> (W - BETA));
    x_new      = (x_ror + y_q) ^ round_key;
    y_new      = y_rol ^ x_new;
    last_round = (round_q == RW'(ROUNDS - 1));
    accept     = start && (state_q != RUN);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. start is only honoured when no operation is in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = RUN;
      RUN:      if (last_round) state_d = FINISHED;
      FINISHED: if (start) state_d = RUN;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath and output next values: load on accept, round while running,
  // and publish the result on the final round.
  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    round_d = round_q;
    ct_x_d  = ct_x_q;
    ct_y_d  = ct_y_q;
    done_d  = done_q;
    busy_d  = busy_q;
    if (accept) begin
      x_d     = pt_x;
      y_d     = pt_y;
      round_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else if (state_q == RUN) begin
      x_d     = x_new;
      y_d     = y_new;
      round_d = round_q + RW'(1);
      if (last_round) begin
        ct_x_d = x_new;
        ct_y_d = y_new;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  // Datapath and output registers. Reset clears everything, so a run that is
  // aborted leaves no partial result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      round_q <= '0;
      ct_x_q  <= '0;
      ct_y_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      round_q <= round_d;
      ct_x_q  <= ct_x_d;
      ct_y_q  <= ct_y_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign ct_x = ct_x_q;
  assign ct_y = ct_y_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_speck_encrypt_iter.sv
// Scoreboard bench for speck_encrypt_iter.
// The bench builds the SPECK64/128 key schedule itself and keeps a reference
// encryption model. Expected ciphertexts are queued at each start and compared
// at completion.
module tb_speck_encrypt_iter;

  localparam int W      = 32;
  localparam int ROUNDS = 27;
  localparam logic [63:0] KAT_CT = 64'h8c6fa548_454e028b;
  localparam logic [31:0] KAT_X  = 32'h3b726574;
  localparam logic [31:0] KAT_Y  = 32'h7475432d;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [W-1:0]        pt_x;
  logic [W-1:0]        pt_y;
  logic [W*ROUNDS-1:0] rk_flat;
  logic [W-1:0]        ct_x;
  logic [W-1:0]        ct_y;
  logic                done;
  logic                busy;

  logic [31:0] rk [ROUNDS];
  logic [63:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;

  speck_encrypt_iter #(.W(W), .ROUNDS(ROUNDS), .ALPHA(8), .BETA(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pt_x    (pt_x),
    .pt_y    (pt_y),
    .rk_flat (rk_flat),
    .ct_x    (ct_x),
    .ct_y    (ct_y),
    .done    (done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror32(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [63:0] model(input logic [31:0] px, input logic [31:0] py);
    logic [31:0] x;
    logic [31:0] y;
    x = px;
    y = py;
    for (int r = 0; r < ROUNDS; r++) begin
      x = (ror32(x, 8) + y) ^ rk[r];
      y = rol32(y, 3) ^ x;
    end
    return {x, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // SPECK64/128 key schedule for key words K3..K0.
  task automatic build_keys();
    logic [31:0] l [ROUNDS + 2];
    logic [31:0] k;
    k    = 32'h03020100;
    l[0] = 32'h0b0a0908;
    l[1] = 32'h13121110;
    l[2] = 32'h1b1a1918;
    rk[0] = k;
    for (int i = 0; i < ROUNDS - 1; i++) begin
      l[i+3]  = (k + ror32(l[i], 8)) ^ 32'(i);
      k       = rol32(k, 3) ^ l[i+3];
      rk[i+1] = k;
    end
    for (int i = 0; i < ROUNDS; i++) rk_flat[32*i +: 32] = rk[i];
  endtask

  // Called at a negedge: drive start and the plaintext, and queue the expected result.
  task automatic launch(input logic [31:0] px, input logic [31:0] py);
    pt_x  = px;
    pt_y  = py;
    start = 1'b1;
    sb.push_back(model(px, py));
  endtask

  // Follow one operation from its start edge to completion.
  // hold: number of edges start stays high. inj_k: cycle at which a spurious
  // start with a new plaintext is pulsed. chg_k: cycle at which pt_x is changed.
  task automatic run_watch(input int hold, input int inj_k, input int chg_k, input string tag);
    logic [63:0] old_ct;
    logic [63:0] exp_ct;
    int lat;
    int busy_cnt;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_fall"}, 64'(done), 64'd0);
    check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    old_ct   = {ct_x, ct_y};
    busy_cnt = busy ? 1 : 0;
    lat      = 0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (busy) busy_cnt++;
        if (done) begin
          lat = k;
          break;
        end
        check({tag, "_ct_hold"}, {ct_x, ct_y}, old_ct);
      end
      start = (k < hold - 1) || (k == inj_k);
      if (k == inj_k) begin
        pt_x = $urandom;
        pt_y = $urandom;
      end
      if (k == chg_k) pt_x = 32'hdeadbeef;
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'd27);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd27);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
    end else begin
      exp_ct = sb.pop_front();
      check({tag, "_ct"}, {ct_x, ct_y}, exp_ct);
    end
    $display("op %s: ct=%h_%h latency=%0d busy_cycles=%0d", tag, ct_x, ct_y, lat, busy_cnt);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    pt_x  = '0;
    pt_y  = '0;
    rk_flat = '0;
    build_keys();
    #1;
    check("rst_ct", {ct_x, ct_y}, 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Known-answer test.
    launch(KAT_X, KAT_Y);
    run_watch(1, -1, -1, "kat");
    check("kat_const", {ct_x, ct_y}, KAT_CT);
    @(negedge clk);
    check("kat_done_held", 64'(done), 64'd1);
    check("kat_ct_held", {ct_x, ct_y}, KAT_CT);

    // Back-to-back run with an all-zero plaintext.
    launch(32'h0, 32'h0);
    run_watch(1, -1, -1, "b2b_zero");

    // A start pulsed during RUN must be ignored.
    launch(KAT_X, KAT_Y);
    run_watch(1, 10, -1, "start_in_run");
    check("start_in_run_const", {ct_x, ct_y}, KAT_CT);

    // A start at the edge where FINISHED is entered must be ignored.
    launch($urandom, $urandom);
    run_watch(1, 26, -1, "start_at_finish");
    @(negedge clk);
    check("finish_edge_done", 64'(done), 64'd1);
    check("finish_edge_busy", 64'(busy), 64'd0);

    // Start held for 5 cycles while pt_x changes late: one run with the first plaintext.
    launch(KAT_X, KAT_Y);
    run_watch(5, -1, 1, "held_start");
    check("held_start_const", {ct_x, ct_y}, KAT_CT);
    repeat (3) @(negedge clk);
    check("held_single_done", 64'(done), 64'd1);
    check("held_single_busy", 64'(busy), 64'd0);

    // Reset between clock edges at cycle 13 of a run.
    launch(32'h01234567, 32'h89abcdef);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ct", {ct_x, ct_y}, 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(KAT_X, KAT_Y);
    run_watch(1, -1, -1, "after_rst");
    check("after_rst_const", {ct_x, ct_y}, KAT_CT);

    // A few random plaintexts.
    for (int i = 0; i < 3; i++) begin
      launch($urandom, $urandom);
      run_watch(1, -1, -1, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/speck_encrypt_iter.md
SPECK_ENCRYPT_ITER -- requirements
Module: speck_encrypt_iter

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
  W  32  word width in bits
  ROUNDS  27  number of SPECK rounds (SPECK64/128)
  ALPHA  8  right-rotate amount applied to x
  BETA  3  left-rotate amount applied to y
REQ-002 Ports SHALL be (one per line: name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  start  in  1  one-cycle request to encrypt pt_x/pt_y
  pt_x  in  W  plaintext upper word
  pt_y  in  W  plaintext lower word
  rk_flat  in  W*ROUNDS  round keys; key r = rk_flat[W*r +: W]
  ct_x  out  W  ciphertext upper word (registered)
  ct_y  out  W  ciphertext lower word (registered)
  done  out  1  level: result valid; held until next accepted start or reset
  busy  out  1  high while rounds are executing
REQ-003 One clock and one reset SHALL be used: clk, and rst (asynchronous, active-high).

Function
REQ-004 FSM states SHALL be IDLE, RUN and FINISHED; reset state is IDLE.
REQ-005 In IDLE or FINISHED, start=1 at edge N SHALL latch pt_x/pt_y into internal x/y, clear round counter to 0, drive done=0 and busy=1, and enter RUN.
REQ-006 start SHALL be ignored while in RUN; no restart, no state change, no output change.
REQ-007 Each RUN edge SHALL apply one round using k = rk_flat[W*round +: W]: x' = (ROR(x,ALPHA) + y) mod 2^W, then XOR k; y' = ROL(y,BETA) XOR x'.
REQ-008 Addition SHALL wrap modulo 2^W; the carry-out SHALL be discarded.
REQ-009 The round counter SHALL be at least ceil(log2(ROUNDS+1)) bits and SHALL increment by 1 per RUN edge.
REQ-010 On the edge applying round ROUNDS-1 (edge N+ROUNDS), the round outputs SHALL load ct_x/ct_y, set done=1 and busy=0, and enter FINISHED.
REQ-011 Latency: done SHALL first read 1 in the cycle after edge N+ROUNDS (27 cycles after the start edge at default parameters).
REQ-012 done SHALL fall at the edge that accepts the next start (edge N) and SHALL read 0 in the cycle after a start pulse, so a caller can wait for the fall of done before waiting for its rise.
REQ-013 ct_x/ct_y SHALL hold the last result until the next completion and SHALL NOT change during RUN.
REQ-014 rk_flat SHALL be read combinationally each RUN cycle and is not latched; the caller holds it stable from start until done.
REQ-015 pt_x/pt_y SHALL be sampled only at the accepting edge; later changes SHALL have no effect.
REQ-016 start asserted for several cycles SHALL launch exactly one operation. Extra cycles fall in RUN and are ignored per REQ-006.
REQ-017 start at the same edge at which FINISHED is entered SHALL be ignored, because the FSM is still in RUN at that edge.

Reset
REQ-018 rst=1 SHALL immediately (without waiting for clk) force state=IDLE, x=y=0, round=0, ct_x=ct_y=0, done=0, busy=0.
REQ-019 rst asserted mid-RUN SHALL abort the operation with no partial result visible. After release, the first start SHALL behave exactly as after power-up.

Verification
REQ-020 Known-answer test. Stimulus: rk_flat generated by the bench's SPECK64/128 key schedule from key words (K3..K0) 1b1a1918 13121110 0b0a0908 03020100; pt_x=3b726574, pt_y=7475432d; start for one cycle. Required response: ct_x=8c6fa548, ct_y=454e028b, done rises exactly 27 cycles after the start edge, and busy is high for exactly those 27 cycles.
REQ-021 Back-to-back operations. Stimulus: with done=1, pulse start with the same key and pt 00000000/00000000. Required response: done reads 0 the next cycle; ct_x/ct_y hold the old value until completion; the new result matches the model.
REQ-022 Start during RUN. Stimulus: pulse start again at cycle 10 of a run with different pt. Required response: the result and timing are identical to the known-answer test.
REQ-023 Mid-operation reset. Stimulus: assert rst at cycle 13 of a run, between clock edges. Required response: all outputs read 0 before the next edge; a fresh known-answer run then passes.
REQ-024 Held start and late pt change. Stimulus: hold start for 5 cycles and change pt_x in cycle 2. Required response: exactly one operation, using the pt sampled at the first edge.
